multicycle_ctrl_fsm: RTL

Main control state machine for the multicycle RISC-V core. It sequences the shared datapath (one memory, one ALU, one instruction register) through fetch, decode, execute, memory and writeback steps for lw, sw, R-type, addi-class I-type, beq and jal. It drives every mux select and write strobe, and computes the PC write enable from the branch flag and the ALU zero flag. It sits alongside the ALU decoder, which consumes `alu_op`.

---
 rtl/multicycle_ctrl_fsm.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle RISC-V core: sequences fetch/decode/execute/mem/writeback.
// Optional memory wait states are enabled by defining MULTICYCLE_MEMWAIT_EN.
module multicycle_ctrl_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       mem_req,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADR   = 4'd3,
    MEMREAD  = 4'd4,
    MEMWB    = 4'd5,
    MEMWRITE = 4'd6,
    EXECR    = 4'd7,
    ALUWB    = 4'd8,
    EXECI    = 4'd9,
    JAL      = 4'd10,
    BEQ      = 4'd11,
    TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t state_reg, state_next;
  logic   started;
  logic   pc_update;
  logic   branch;
  logic   ready;

`ifdef MULTICYCLE_MEMWAIT_EN
  assign ready = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign ready = 1'b1;
`endif

  // 'started' keeps IDLE for one full cycle after reset release, so FETCH lands on the 2nd edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      started   <= 1'b0;
    end else begin
      state_reg <= state_next;
      started   <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    mem_req    = 1'b0;
    ir_write   = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_reg)
      IDLE: if (started) state_next = FETCH;
      FETCH: begin
        mem_req    = 1'b1;
        ir_write   = ready;
        pc_update  = ready;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (ready) state_next = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_ADDI:      state_next = EXECI;
          OP_JAL:       state_next = JAL;
          OP_BEQ:       state_next = BEQ;
          default:      state_next = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        mem_req = 1'b1;
        if (ready) state_next = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        adr_src    = 1'b1;
        mem_req    = 1'b1;
        mem_write  = 1'b1;
        instr_done = ready;
        if (ready) state_next = FETCH;
      end
      EXECR: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_update  = 1'b1;
        state_next = ALUWB;
      end
      BEQ: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      TRAP: begin
        illegal    = 1'b1;
        state_next = TRAP;
      end
      default: state_next = IDLE;
    endcase
  end

  assign pc_write = pc_update | (branch & zero);

  // Immediate format follows the opcode in every state, but is held at 0 while in reset.
  always_comb begin
    imm_src = 2'b00;
    if (rst_n) begin
      case (op)
        OP_SW:   imm_src = 2'b01;
        OP_BEQ:  imm_src = 2'b10;
        OP_JAL:  imm_src = 2'b11;
        default: imm_src = 2'b00;
      endcase
    end
  end

endmodule
